// File: rtl/conf.sv
// Configuration address/data register pair: CAR holds the broadcast configuration address,
// CDR is a window onto whichever configuration source claims that address.
module conf #(
  parameter logic [12:0] ADDR_BASE = 13'o17720
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] reg_addr,
  input  logic        reg_bs7,
  output logic        reg_addr_match,
  output logic [15:0] reg_rdata,
  input  logic [15:0] reg_wdata,
  input  logic        reg_write,
  output logic [15:0] conf_addr,
  output logic        conf_write,
  input  logic        tl_match,
  input  logic [15:0] tl_rdata,
  input  logic        dev0_match,
  input  logic [15:0] dev0_rdata,
  input  logic        dev1_match,
  input  logic [15:0] dev1_rdata,
  input  logic        dev2_match,
  input  logic [15:0] dev2_rdata,
  input  logic        dev3_match,
  input  logic [15:0] dev3_rdata
);

  // Word addresses; bit 0 of the byte address is ignored.
  localparam logic [11:0] CarWord = ADDR_BASE[12:1];
  localparam logic [11:0] CdrWord = CarWord + 12'd1;

  logic        car_hit;
  logic        cdr_hit;
  logic [15:0] car_q;
  logic [15:0] car_d;
  logic [15:0] src_rdata;

  always_comb begin
    car_hit = reg_bs7 && (reg_addr[12:1] == CarWord);
    cdr_hit = reg_bs7 && (reg_addr[12:1] == CdrWord);
  end

  // Fixed-priority source select: tl first, then dev0..dev3.
  always_comb begin
    src_rdata = 16'd0;
    if (tl_match) begin
      src_rdata = tl_rdata;
    end else if (dev0_match) begin
      src_rdata = dev0_rdata;
    end else if (dev1_match) begin
      src_rdata = dev1_rdata;
    end else if (dev2_match) begin
      src_rdata = dev2_rdata;
    end else if (dev3_match) begin
      src_rdata = dev3_rdata;
    end
  end

  always_comb begin
    reg_addr_match = car_hit || cdr_hit;
    conf_write     = reg_write && cdr_hit;
    conf_addr      = car_q;
    reg_rdata      = 16'd0;
    if (car_hit) begin
      reg_rdata = car_q;
    end else if (cdr_hit) begin
      reg_rdata = src_rdata;
    end
  end

  always_comb begin
    car_d = car_q;
    if (reg_write && car_hit) begin
      car_d = reg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      car_q <= 16'd0;
    end else begin
      car_q <= car_d;
    end
  end

endmodule

// File: tb/tb_conf.sv
// Self-checking bench for conf: directed scenarios followed by randomized traffic
// compared against a behavioural model of the register pair.
module tb_conf;

  localparam logic [12:0] Base = 13'o17720;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] reg_addr;
  logic        reg_bs7;
  logic        reg_addr_match;
  logic [15:0] reg_rdata;
  logic [15:0] reg_wdata;
  logic        reg_write;
  logic [15:0] conf_addr;
  logic        conf_write;
  logic        tl_match, dev0_match, dev1_match, dev2_match, dev3_match;
  logic [15:0] tl_rdata, dev0_rdata, dev1_rdata, dev2_rdata, dev3_rdata;

  int checks = 0;
  int failures = 0;
  logic [15:0] model_car;

  conf #(.ADDR_BASE(Base)) dut (
    .clk           (clk),
    .reset         (reset),
    .reg_addr      (reg_addr),
    .reg_bs7       (reg_bs7),
    .reg_addr_match(reg_addr_match),
    .reg_rdata     (reg_rdata),
    .reg_wdata     (reg_wdata),
    .reg_write     (reg_write),
    .conf_addr     (conf_addr),
    .conf_write    (conf_write),
    .tl_match      (tl_match),
    .tl_rdata      (tl_rdata),
    .dev0_match    (dev0_match),
    .dev0_rdata    (dev0_rdata),
    .dev1_match    (dev1_match),
    .dev1_rdata    (dev1_rdata),
    .dev2_match    (dev2_match),
    .dev2_rdata    (dev2_rdata),
    .dev3_match    (dev3_match),
    .dev3_rdata    (dev3_rdata)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge, outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sources();
    {tl_match, dev0_match, dev1_match, dev2_match, dev3_match} = 5'b0;
    {tl_rdata, dev0_rdata, dev1_rdata, dev2_rdata, dev3_rdata} = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; reg_bs7 = 1'b1; reg_addr = 13'o17720; reg_write = 1'b0; reg_wdata = 16'd0;
    clear_sources();
    tick();
    tick();
    checks++;
    if (reg_addr_match !== 1'b1) begin
      failures++; $display("FAIL reset_match got=%b exp=1", reg_addr_match);
    end
    checks++;
    if (reg_rdata !== 16'd0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0000", reg_rdata);
    end
    checks++;
    if (conf_addr !== 16'd0) begin
      failures++; $display("FAIL reset_conf_addr got=%h exp=0000", conf_addr);
    end
    reset = 1'b0;
    model_car = 16'd0;
  endtask

  task automatic test_car_write();
    reg_addr = 13'o17720; reg_wdata = 16'd18; reg_write = 1'b1;
    #1;
    checks++;
    if (conf_write !== 1'b0) begin
      failures++; $display("FAIL car_write_cw got=%b exp=0", conf_write);
    end
    checks++;
    if (conf_addr !== 16'd0) begin
      failures++; $display("FAIL car_before_edge got=%h exp=0000", conf_addr);
    end
    @(posedge clk); #1;
    reg_write = 1'b0;
    #1;
    checks++;
    if (conf_addr !== 16'd18) begin
      failures++; $display("FAIL car_conf_addr got=%h exp=0012", conf_addr);
    end
    checks++;
    if (reg_rdata !== 16'd18) begin
      failures++; $display("FAIL car_readback got=%h exp=0012", reg_rdata);
    end
    checks++;
    if (conf_write !== 1'b0) begin
      failures++; $display("FAIL car_after_cw got=%b exp=0", conf_write);
    end
    model_car = 16'd18;
  endtask

  task automatic test_cdr_read();
    reg_addr = 13'o17722;
    dev0_match = 1'b1; dev0_rdata = 16'h4210;
    dev1_match = 1'b1; dev1_rdata = 16'h7777;
    #1;
    checks++;
    if (reg_rdata !== 16'h4210) begin
      failures++; $display("FAIL cdr_dev0 got=%h exp=4210", reg_rdata);
    end
    tl_match = 1'b1; tl_rdata = 16'h1111;
    #1;
    checks++;
    if (reg_rdata !== 16'h1111) begin
      failures++; $display("FAIL cdr_tl got=%h exp=1111", reg_rdata);
    end
    clear_sources();
    dev3_rdata = 16'hBEEF;
    #1;
    checks++;
    if (reg_rdata !== 16'd0 || reg_addr_match !== 1'b1) begin
      failures++; $display("FAIL cdr_nomatch got=%h/%b exp=0000/1", reg_rdata, reg_addr_match);
    end
  endtask

  task automatic test_cdr_write();
    reg_addr = 13'o17722; reg_wdata = 16'hABCD; reg_write = 1'b1;
    #1;
    checks++;
    if (conf_write !== 1'b1) begin
      failures++; $display("FAIL cdr_cw_high got=%b exp=1", conf_write);
    end
    @(posedge clk); #1;
    reg_write = 1'b0;
    #1;
    checks++;
    if (conf_write !== 1'b0) begin
      failures++; $display("FAIL cdr_cw_low got=%b exp=0", conf_write);
    end
    checks++;
    if (conf_addr !== 16'd18) begin
      failures++; $display("FAIL cdr_car_kept got=%h exp=0012", conf_addr);
    end
  endtask

  task automatic test_miss();
    reg_write = 1'b1; reg_wdata = 16'h5A5A;
    reg_addr = 13'o17724; reg_bs7 = 1'b1;
    tl_match = 1'b1; tl_rdata = 16'h2222;
    #1;
    checks++;
    if (reg_addr_match !== 1'b0 || reg_rdata !== 16'd0 || conf_write !== 1'b0) begin
      failures++;
      $display("FAIL miss_o17724 got=%b/%h/%b exp=0/0000/0", reg_addr_match, reg_rdata, conf_write);
    end
    @(posedge clk); #1;
    reg_addr = 13'o17720; reg_bs7 = 1'b0;
    #1;
    checks++;
    if (reg_addr_match !== 1'b0 || reg_rdata !== 16'd0 || conf_write !== 1'b0) begin
      failures++;
      $display("FAIL miss_bs7 got=%b/%h/%b exp=0/0000/0", reg_addr_match, reg_rdata, conf_write);
    end
    reg_addr = 13'o17722;
    #1;
    checks++;
    if (conf_write !== 1'b0) begin
      failures++; $display("FAIL miss_bs7_cdr_cw got=%b exp=0", conf_write);
    end
    @(posedge clk); #1;
    reg_write = 1'b0; reg_bs7 = 1'b1;
    clear_sources();
    #1;
    checks++;
    if (conf_addr !== 16'd18) begin
      failures++; $display("FAIL miss_car_kept got=%h exp=0012", conf_addr);
    end
  endtask

  task automatic test_reset_override();
    reset = 1'b1; reg_addr = 13'o17720; reg_bs7 = 1'b1;
    reg_wdata = 16'h0055; reg_write = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; reg_write = 1'b0;
    #1;
    checks++;
    if (conf_addr !== 16'd0) begin
      failures++; $display("FAIL reset_override got=%h exp=0000", conf_addr);
    end
    model_car = 16'd0;
  endtask

  // Reference: find the first claiming source in priority order.
  function automatic logic [15:0] ref_src(input logic [4:0] m, input logic [15:0] d0,
                                          input logic [15:0] d1, input logic [15:0] d2,
                                          input logic [15:0] d3, input logic [15:0] d4);
    logic [15:0] vals [5];
    vals[0] = d0; vals[1] = d1; vals[2] = d2; vals[3] = d3; vals[4] = d4;
    for (int i = 0; i < 5; i++) begin
      if (m[4-i]) return vals[i];
    end
    return 16'd0;
  endfunction

  task automatic test_random();
    int unsigned sel;
    int unsigned word;
    int unsigned base_word;
    bit          hit_car, hit_cdr;
    logic [15:0] exp_rdata;
    base_word = int'(Base) / 2;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1:    reg_addr = Base + 13'($urandom_range(0, 1));
        2, 3:    reg_addr = Base + 13'd2 + 13'($urandom_range(0, 1));
        4:       reg_addr = Base + 13'd4;
        default: reg_addr = 13'($urandom);
      endcase
      reg_bs7   = ($urandom_range(0, 7) != 0);
      reg_write = $urandom_range(0, 1) == 1;
      reg_wdata = 16'($urandom);
      reset     = ($urandom_range(0, 19) == 0);
      {tl_match, dev0_match, dev1_match, dev2_match, dev3_match} = 5'($urandom);
      tl_rdata = 16'($urandom); dev0_rdata = 16'($urandom); dev1_rdata = 16'($urandom);
      dev2_rdata = 16'($urandom); dev3_rdata = 16'($urandom);
      #1;
      word    = int'(reg_addr) / 2;
      hit_car = reg_bs7 && (word == base_word);
      hit_cdr = reg_bs7 && (word == base_word + 1);
      exp_rdata = hit_car ? model_car :
                  hit_cdr ? ref_src({tl_match, dev0_match, dev1_match, dev2_match, dev3_match},
                                    tl_rdata, dev0_rdata, dev1_rdata, dev2_rdata, dev3_rdata)
                          : 16'd0;
      checks++;
      if (reg_addr_match !== (hit_car || hit_cdr)) begin
        failures++;
        $display("FAIL rand_match n=%0d addr=%o got=%b exp=%b", n, reg_addr, reg_addr_match,
                 hit_car || hit_cdr);
      end
      checks++;
      if (reg_rdata !== exp_rdata) begin
        failures++;
        $display("FAIL rand_rdata n=%0d addr=%o got=%h exp=%h", n, reg_addr, reg_rdata, exp_rdata);
      end
      checks++;
      if (conf_write !== (reg_write && hit_cdr)) begin
        failures++;
        $display("FAIL rand_cw n=%0d got=%b exp=%b", n, conf_write, reg_write && hit_cdr);
      end
      checks++;
      if (conf_addr !== model_car) begin
        failures++;
        $display("FAIL rand_conf_addr n=%0d got=%h exp=%h", n, conf_addr, model_car);
      end
      @(posedge clk);
      if (reset) model_car = 16'd0;
      else if (reg_write && hit_car) model_car = reg_wdata;
      #1;
    end
    reset = 1'b0; reg_write = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_car_write();
    test_cdr_read();
    test_cdr_write();
    test_miss();
    test_reset_override();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conf.md
CONF -- requirements
Module: conf

Interface
REQ-001 Parameter ADDR_BASE, default 13'o17720, SHALL set the even byte address of the register pair within the I/O page.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous and active-high.
REQ-004 reg_addr  input  13  bus byte address within the I/O page; bit 0 is ignored.
REQ-005 reg_bs7  input  1  I/O-page select qualifying reg_addr.
REQ-006 reg_addr_match  output  1  asserted when the bus address hits one of this block's registers.
REQ-007 reg_rdata  output  16  read data for the addressed register.
REQ-008 reg_wdata  input  16  bus write data.
REQ-009 reg_write  input  1  one-cycle bus write strobe.
REQ-010 conf_addr  output  16  configuration address broadcast to all configuration sources.
REQ-011 conf_write  output  1  configuration write strobe broadcast with reg_wdata.
REQ-012 tl_match, dev0_match … dev3_match  input  1 each  source claims the current conf_addr.
REQ-013 tl_rdata, dev0_rdata … dev3_rdata  input  16 each  read data from each source.

Function
REQ-014 The block SHALL decode two word registers: CAR (configuration address register) at ADDR_BASE and CDR (configuration data register) at ADDR_BASE+2.
REQ-015 A register SHALL be hit when reg_bs7=1 and reg_addr[12:1] equals (ADDR_BASE[12:1]+offset/2); all other addresses, and all addresses with reg_bs7=0, SHALL miss.
REQ-016 reg_addr_match SHALL be combinational: 1 on a hit to CAR or CDR, else 0.
REQ-017 conf_addr SHALL always equal the contents of CAR.
REQ-018 CAR SHALL load all 16 bits of reg_wdata on the clock edge on which reg_write=1 and CAR is hit.
REQ-019 Writes SHALL be word-wide; there is no byte-lane masking.
REQ-020 conf_write SHALL be combinational and equal reg_write AND CDR hit, so it is high in the same cycle as reg_write; sources capture reg_wdata at conf_addr on that edge.
REQ-021 This block SHALL store no CDR data and a CDR write SHALL NOT change CAR.
REQ-022 conf_write SHALL be 0 whenever reg_write=0 or CDR is not hit.
REQ-023 reg_rdata SHALL be combinational: CAR contents on a CAR hit; the source mux value on a CDR hit; 16'd0 on a miss.
REQ-024 Source mux priority SHALL be, highest first: tl, dev0, dev1, dev2, dev3; the output is the rdata of the highest-priority asserted match.
REQ-025 When no source match is asserted, a CDR read SHALL return 16'd0.
REQ-026 There is no auto-increment; CAR changes only on a CAR write or on reset.

Reset
REQ-027 On a clock edge with reset=1, CAR SHALL clear to 16'd0; reset SHALL override a simultaneous CAR write.
REQ-028 During reset the combinational outputs SHALL follow their normal rules, with conf_addr=0.

Verification (ADDR_BASE=13'o17720)
REQ-029 Reset, then reg_bs7=1 and reg_addr=o17720 -> reg_addr_match=1, reg_rdata=0, conf_addr=0.
REQ-030 Write 16'd18 to o17720 -> conf_addr=18 from the next cycle; a read of o17720 returns 18; conf_write stays 0 throughout.
REQ-031 With conf_addr=18 and dev0_match=1, dev0_rdata=16'h4210, read o17722 -> reg_rdata=16'h4210; additionally asserting tl_match with tl_rdata=16'h1111 -> reg_rdata=16'h1111.
REQ-032 Write 16'hABCD to o17722 -> conf_write=1 for exactly the reg_write cycle; conf_addr is unchanged.
REQ-033 Address o17724, or o17720 with reg_bs7=0 -> reg_addr_match=0, reg_rdata=0, conf_write=0 even when reg_write=1.
REQ-034 reset=1 and a CAR write of 16'h0055 on the same edge -> conf_addr=0 afterwards.
